// File: rtl/qupls_mem_slots_pkg.sv
// Shared types for the Qupls multi-slot memory-request tracker.
// Every slot of qupls_mem_slots walks through the states of mem_slot_state_t.
package qupls_mem_slots_pkg;

  typedef enum logic [2:0] {
    MS_AVAIL    = 3'd0,
    MS_RESERVED = 3'd1,
    MS_READY    = 3'd2,
    MS_ACTIVE   = 3'd3,
    MS_DELAY    = 3'd4
  } mem_slot_state_t;

endpackage

// File: rtl/qupls_mem_slots_if.sv
// Load/store-queue side bus of the slot tracker: allocation, per-slot control,
// memory issue/ack and status. slave = tracker, master = queue/memory side.
interface qupls_mem_slots_if #(
  parameter int NSLOT = 4,
  parameter int TAGW  = $clog2(NSLOT)
);
  import qupls_mem_slots_pkg::*;

  logic             alloc_req_i;
  logic             alloc_gnt_o;
  logic [TAGW-1:0]  alloc_tag_o;
  logic [NSLOT-1:0] set_ready_i;
  logic [NSLOT-1:0] set_avail_i;
  logic             issue_v_o;
  logic [TAGW-1:0]  issue_tag_o;
  logic             issue_rdy_i;
  logic             ack_i;
  logic [TAGW-1:0]  ack_tag_i;
  logic [NSLOT-1:0] err_o;
  mem_slot_state_t  state_o [NSLOT];
  logic [TAGW:0]    avail_cnt_o;
  logic             full_o;
  logic             empty_o;

  modport slave (
    input  alloc_req_i, set_ready_i, set_avail_i, issue_rdy_i, ack_i, ack_tag_i,
    output alloc_gnt_o, alloc_tag_o, issue_v_o, issue_tag_o, err_o, state_o,
           avail_cnt_o, full_o, empty_o
  );

  modport master (
    output alloc_req_i, set_ready_i, set_avail_i, issue_rdy_i, ack_i, ack_tag_i,
    input  alloc_gnt_o, alloc_tag_o, issue_v_o, issue_tag_o, err_o, state_o,
           avail_cnt_o, full_o, empty_o
  );

endinterface

// File: rtl/qupls_mem_slot.sv
// Single memory-request slot: lifecycle FSM with post-ack delay, ACTIVE timeout
// and bounded reissue. Events arrive already decoded for this slot.
module qupls_mem_slot
  import qupls_mem_slots_pkg::*;
#(
  parameter int DELAY    = 1,
  parameter int TMO      = 255,
  parameter int MAXRETRY = 3
)(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_grant,
  input  logic            i_set_ready,
  input  logic            i_set_avail,
  input  logic            i_issue,
  input  logic            i_ack,
  output mem_slot_state_t o_state,
  output logic            o_err
);

  localparam int DW = (DELAY < 2) ? 1 : $clog2(DELAY);
  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);
  localparam int RW = (MAXRETRY < 1) ? 1 : $clog2(MAXRETRY + 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAXRETRY);

  mem_slot_state_t r_state, w_state;
  logic [DW-1:0]   r_dly, w_dly;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic [RW-1:0]   r_retry, w_retry;
  logic            r_err, w_err;
  logic            w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MS_AVAIL;
      r_dly   <= '0;
      r_tmo   <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_dly   <= w_dly;
      r_tmo   <= w_tmo;
      r_retry <= w_retry;
      r_err   <= w_err;
    end
  end

  // r_tmo holds completed ACTIVE cycles, so the current cycle is number r_tmo+1
  assign w_timeout = (TMO != 0) && (r_state == MS_ACTIVE) && (r_tmo == TMO_LAST);

  always_comb begin
    w_state = r_state;
    w_dly   = r_dly;
    w_tmo   = r_tmo;
    w_retry = r_retry;
    w_err   = 1'b0;
    if (i_set_avail) begin
      w_state = MS_AVAIL;
      w_retry = '0;
    end else if (i_set_ready && (r_state == MS_AVAIL || r_state == MS_RESERVED)) begin
      w_state = MS_READY;
    end else if (i_ack && r_state == MS_ACTIVE) begin
      w_state = MS_DELAY;
      w_dly   = '0;
      w_retry = '0;
    end else if (w_timeout) begin
      if (r_retry < RETRY_MAX) begin
        w_state = MS_READY;
        w_retry = r_retry + 1'b1;
      end else begin
        w_state = MS_AVAIL;
        w_retry = '0;
        w_err   = 1'b1;
      end
    end else begin
      case (r_state)
        MS_AVAIL:  if (i_grant) w_state = MS_RESERVED;
        MS_READY:  if (i_issue) begin
                     w_state = MS_ACTIVE;
                     w_tmo   = '0;
                   end
        MS_ACTIVE: w_tmo = r_tmo + 1'b1;
        MS_DELAY:  if (r_dly == DLY_LAST) w_state = MS_AVAIL;
                   else                   w_dly   = r_dly + 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    o_state = r_state;
    o_err   = r_err;
  end

endmodule

// File: rtl/qupls_mem_slots.sv
// Multi-slot memory-request tracker: NSLOT slot FSMs plus a lowest-index free
// allocator, a round-robin issue arbiter, tag-routed acks and status counts.
module qupls_mem_slots
  import qupls_mem_slots_pkg::*;
#(
  parameter int NSLOT    = 4,
  parameter int TAGW     = $clog2(NSLOT),
  parameter int DELAY    = 1,
  parameter int TMO      = 255,
  parameter int MAXRETRY = 3
)(
  input logic              clk_i,
  input logic              rst_i,
  qupls_mem_slots_if.slave bus
);

  mem_slot_state_t  w_state [NSLOT];
  logic [NSLOT-1:0] w_avail, w_cand, w_grant, w_issue, w_ack, w_err;
  logic [TAGW-1:0]  w_alloc_tag, w_issue_tag, w_next_tag, r_ptr;
  logic             w_alloc_any, w_gnt, w_issue_v, w_xfer;
  logic [TAGW:0]    w_cnt;

  always_comb begin
    w_alloc_any = 1'b0;
    w_alloc_tag = '0;
    w_cnt       = '0;
    for (int n = NSLOT - 1; n >= 0; n--) begin
      if (w_avail[n]) begin
        w_alloc_any = 1'b1;
        w_alloc_tag = TAGW'(n);
      end
      w_cnt = w_cnt + {{TAGW{1'b0}}, w_avail[n]};
    end
  end

  assign w_gnt = bus.alloc_req_i & w_alloc_any;

  // Scan downward so the candidate nearest the pointer is the one kept
  always_comb begin
    logic [TAGW-1:0] w_idx;
    w_issue_v   = 1'b0;
    w_issue_tag = '0;
    w_idx       = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      w_idx = TAGW'((int'(r_ptr) + i) % NSLOT);
      if (w_cand[w_idx]) begin
        w_issue_v   = 1'b1;
        w_issue_tag = w_idx;
      end
    end
  end

  assign w_xfer     = w_issue_v & bus.issue_rdy_i;
  assign w_next_tag = (w_issue_tag == TAGW'(NSLOT - 1)) ? '0 : w_issue_tag + 1'b1;

  // A stalled offer pins the pointer on itself, keeping the tag stable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_ptr <= '0;
    else if (w_issue_v) r_ptr <= bus.issue_rdy_i ? w_next_tag : w_issue_tag;
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    assign w_avail[g] = (w_state[g] == MS_AVAIL);
    assign w_cand[g]  = (w_state[g] == MS_READY) & ~bus.set_avail_i[g];
    assign w_grant[g] = w_gnt & (w_alloc_tag == TAGW'(g));
    assign w_issue[g] = w_xfer & (w_issue_tag == TAGW'(g));
    assign w_ack[g]   = bus.ack_i & (bus.ack_tag_i == TAGW'(g));

    qupls_mem_slot #(
      .DELAY    (DELAY),
      .TMO      (TMO),
      .MAXRETRY (MAXRETRY)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_grant     (w_grant[g]),
      .i_set_ready (bus.set_ready_i[g]),
      .i_set_avail (bus.set_avail_i[g]),
      .i_issue     (w_issue[g]),
      .i_ack       (w_ack[g]),
      .o_state     (w_state[g]),
      .o_err       (w_err[g])
    );

    assign bus.state_o[g] = w_state[g];
  end

  assign bus.alloc_gnt_o = w_gnt;
  assign bus.alloc_tag_o = w_alloc_tag;
  assign bus.issue_v_o   = w_issue_v;
  assign bus.issue_tag_o = w_issue_tag;
  assign bus.err_o       = w_err;
  assign bus.avail_cnt_o = w_cnt;
  assign bus.full_o      = (w_cnt == '0);
  assign bus.empty_o     = (w_cnt == (TAGW + 1)'(NSLOT));

endmodule

// File: tb/tb_qupls_mem_slots.sv
// Bench for qupls_mem_slots: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural slot model.
module tb_qupls_mem_slots;
  import qupls_mem_slots_pkg::*;

  localparam int NS = 4;
  localparam int TG = 2;
  localparam int DL = 1;
  localparam int TO = 4;
  localparam int MR = 1;

  logic clk;
  logic rst_i;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 0;

  qupls_mem_slots_if #(.NSLOT(NS)) bus ();

  qupls_mem_slots #(.NSLOT(NS), .DELAY(DL), .TMO(TO), .MAXRETRY(MR)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: state per slot plus plain integer counters
  mem_slot_state_t m_st [NS];
  int              m_age [NS];
  int              m_dly [NS];
  int              m_retry [NS];
  logic [NS-1:0]   m_err;
  int              m_rr;

  task automatic model_reset();
    for (int n = 0; n < NS; n++) begin
      m_st[n] = MS_AVAIL; m_age[n] = 0; m_dly[n] = 0; m_retry[n] = 0;
    end
    m_err = '0;
    m_rr  = 0;
  endtask

  function automatic int m_alloc_tag();
    for (int n = 0; n < NS; n++) if (m_st[n] == MS_AVAIL) return n;
    return -1;
  endfunction

  function automatic int m_issue_tag();
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (m_rr + k) % NS;
      if (m_st[s] == MS_READY && !bus.set_avail_i[s]) return s;
    end
    return -1;
  endfunction

  function automatic int m_navail();
    int c;
    c = 0;
    for (int n = 0; n < NS; n++) if (m_st[n] == MS_AVAIL) c++;
    return c;
  endfunction

  task automatic model_step();
    int  at, it;
    bit  gnt, xfer;
    if (rst_i) begin
      model_reset();
      return;
    end
    at   = m_alloc_tag();
    it   = m_issue_tag();
    gnt  = bus.alloc_req_i && at >= 0;
    xfer = bus.issue_rdy_i && it >= 0;
    m_err = '0;
    for (int n = 0; n < NS; n++) begin
      if (bus.set_avail_i[n]) begin
        m_st[n] = MS_AVAIL; m_retry[n] = 0;
      end else if (bus.set_ready_i[n] && (m_st[n] == MS_AVAIL || m_st[n] == MS_RESERVED)) begin
        m_st[n] = MS_READY;
      end else if (bus.ack_i && int'(bus.ack_tag_i) == n && m_st[n] == MS_ACTIVE) begin
        m_st[n] = MS_DELAY; m_dly[n] = 0; m_retry[n] = 0;
      end else if (m_st[n] == MS_ACTIVE && TO != 0 && m_age[n] + 1 == TO) begin
        if (m_retry[n] < MR) begin
          m_st[n] = MS_READY; m_retry[n]++;
        end else begin
          m_st[n] = MS_AVAIL; m_retry[n] = 0; m_err[n] = 1'b1;
        end
      end else if (m_st[n] == MS_AVAIL && gnt && at == n) begin
        m_st[n] = MS_RESERVED;
      end else if (m_st[n] == MS_READY && xfer && it == n) begin
        m_st[n] = MS_ACTIVE; m_age[n] = 0;
      end else if (m_st[n] == MS_ACTIVE) begin
        m_age[n]++;
      end else if (m_st[n] == MS_DELAY) begin
        m_dly[n]++;
        if (m_dly[n] >= DL) m_st[n] = MS_AVAIL;
      end
    end
    if (it >= 0) m_rr = bus.issue_rdy_i ? (it + 1) % NS : it;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int at, it;
      at = m_alloc_tag();
      it = m_issue_tag();
      chk("alloc_gnt", int'(bus.alloc_gnt_o), int'(bus.alloc_req_i && at >= 0));
      if (at >= 0) chk("alloc_tag", int'(bus.alloc_tag_o), at);
      chk("issue_v", int'(bus.issue_v_o), int'(it >= 0));
      if (it >= 0) chk("issue_tag", int'(bus.issue_tag_o), it);
      chk("err", int'(bus.err_o), int'(m_err));
      chk("avail_cnt", int'(bus.avail_cnt_o), m_navail());
      chk("full", int'(bus.full_o), int'(m_navail() == 0));
      chk("empty", int'(bus.empty_o), int'(m_navail() == NS));
      for (int n = 0; n < NS; n++)
        chk($sformatf("state%0d", n), int'(bus.state_o[n]), int'(m_st[n]));
    end
  end

  task automatic idle();
    bus.alloc_req_i = 1'b0;
    bus.set_ready_i = '0;
    bus.set_avail_i = '0;
    bus.issue_rdy_i = 1'b0;
    bus.ack_i       = 1'b0;
    bus.ack_tag_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_reset_view(input string nm);
    for (int n = 0; n < NS; n++)
      chk($sformatf("%s_state%0d", nm, n), int'(bus.state_o[n]), int'(MS_AVAIL));
    chk({nm, "_empty"}, int'(bus.empty_o), 1);
    chk({nm, "_full"}, int'(bus.full_o), 0);
    chk({nm, "_cnt"}, int'(bus.avail_cnt_o), NS);
    chk({nm, "_issue_v"}, int'(bus.issue_v_o), 0);
    chk({nm, "_err"}, int'(bus.err_o), 0);
  endtask

  initial begin
    idle();
    model_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i  = 1'b0;
    chk_on = 1'b1;

    // Reset view and combinational grant
    settle();
    chk_reset_view("rst");
    bus.alloc_req_i = 1'b1;
    settle();
    chk("rst_gnt", int'(bus.alloc_gnt_o), 1);

    // Four allocations, then a refused fifth
    for (int k = 0; k < NS; k++) begin
      bus.alloc_req_i = 1'b1;
      settle();
      chk("alloc_seq_gnt", int'(bus.alloc_gnt_o), 1);
      chk("alloc_seq_tag", int'(bus.alloc_tag_o), k);
      tick();
    end
    settle();
    chk("full_after4", int'(bus.full_o), 1);
    chk("gnt_when_full", int'(bus.alloc_gnt_o), 0);
    chk("state3_reserved", int'(bus.state_o[3]), int'(MS_RESERVED));
    idle();

    // Slots 1 and 3 READY; stalled offer holds tag 1 even when slot 0 turns READY
    bus.set_ready_i = 4'b1010;
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      bus.set_ready_i = (k == 2) ? 4'b0001 : 4'b0000;
      settle();
      chk("stall_v", int'(bus.issue_v_o), 1);
      chk("stall_tag", int'(bus.issue_tag_o), 1);
      tick();
    end
    idle();
    bus.issue_rdy_i = 1'b1;
    settle();
    chk("rr_first", int'(bus.issue_tag_o), 1);
    tick();
    settle();
    chk("rr_second", int'(bus.issue_tag_o), 3);
    tick();
    bus.issue_rdy_i = 1'b0;
    settle();
    chk("rr_wrap", int'(bus.issue_tag_o), 0);
    chk("slot1_active", int'(bus.state_o[1]), int'(MS_ACTIVE));

    // Ack slot 1 -> DELAY one cycle -> AVAIL; ack to READY slot 0 ignored
    bus.ack_i = 1'b1; bus.ack_tag_i = 2'd1;
    tick();
    settle();
    chk("ack_delay", int'(bus.state_o[1]), int'(MS_DELAY));
    bus.ack_tag_i = 2'd0;
    tick();
    idle();
    settle();
    chk("delay_done", int'(bus.state_o[1]), int'(MS_AVAIL));
    chk("ack_ignored", int'(bus.state_o[0]), int'(MS_READY));

    // Slot 3 times out after 4 ACTIVE cycles, is reissued, then abandoned
    tick();
    settle();
    chk("tmo_not_yet", int'(bus.state_o[3]), int'(MS_ACTIVE));
    tick();
    settle();
    chk("tmo_retry", int'(bus.state_o[3]), int'(MS_READY));
    bus.set_avail_i = 4'b0001;
    bus.issue_rdy_i = 1'b1;
    settle();
    chk("cancel_moves_offer", int'(bus.issue_tag_o), 3);
    tick();
    idle();
    repeat (3) tick();
    settle();
    chk("tmo2_not_yet", int'(bus.state_o[3]), int'(MS_ACTIVE));
    chk("err_quiet", int'(bus.err_o), 0);
    tick();
    settle();
    chk("abandon_state", int'(bus.state_o[3]), int'(MS_AVAIL));
    chk("abandon_err", int'(bus.err_o), 4'b1000);
    tick();
    settle();
    chk("err_one_pulse", int'(bus.err_o), 0);

    // Cancel + ack + offer on slot 1 in the same cycle
    bus.set_ready_i = 4'b0110;
    tick();
    idle();
    settle();
    chk("offer1", int'(bus.issue_tag_o), 1);
    bus.set_avail_i = 4'b0010; bus.ack_i = 1'b1; bus.ack_tag_i = 2'd1;
    settle();
    chk("offer_moves", int'(bus.issue_tag_o), 2);
    tick();
    idle();
    settle();
    chk("cancel_avail", int'(bus.state_o[1]), int'(MS_AVAIL));
    bus.issue_rdy_i = 1'b1;
    tick();
    idle();
    bus.set_avail_i = 4'b0100; bus.ack_i = 1'b1; bus.ack_tag_i = 2'd2;
    tick();
    idle();
    settle();
    chk("ack_cancel_avail", int'(bus.state_o[2]), int'(MS_AVAIL));
    tick();
    settle();
    chk("ack_cancel_noerr", int'(bus.err_o), 0);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      bus.alloc_req_i = 1'($urandom_range(1, 0));
      for (int n = 0; n < NS; n++) begin
        bus.set_ready_i[n] = ($urandom_range(3, 0) == 0);
        bus.set_avail_i[n] = ($urandom_range(19, 0) == 0);
      end
      bus.issue_rdy_i = ($urandom_range(9, 0) < 6);
      bus.ack_i       = 1'($urandom_range(1, 0));
      bus.ack_tag_i   = TG'($urandom_range(NS - 1, 0));
      if (i == 1500) begin
        settle();
        rst_i = 1'b1;
        model_reset();
        #1;
        chk_reset_view("async_rst");
        tick();
        rst_i = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
